// File: rtl/pin_test_checker.sv
// Receive-side walking-one pin-test checker: synchronizes the pads, locks onto the
// NPINS+1 cycle pattern, and accumulates per-pin faults, error/frame counts and pass/led status.
module pin_test_checker #(
   parameter int NPINS       = 26,
   parameter int SYNC_STAGES = 2,
   parameter int PASS_FRAMES = 16,
   parameter int LOSS_THRESH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_faults,
   input  logic [NPINS-1:0] pins_in,
   output logic             locked,
   output logic             pass,
   output logic [NPINS-1:0] fault_mask,
   output logic [15:0]      err_count,
   output logic [15:0]      frame_count,
   output logic             led
);

   localparam int CW = $clog2(PASS_FRAMES + 1);
   localparam int MW = $clog2(LOSS_THRESH + 1);
   localparam logic [NPINS-1:0] TOP = {1'b1, {(NPINS-1){1'b0}}};

   typedef enum logic {HUNT, LOCKED} state_t;

   state_t                              state_q, state_d;
   logic [SYNC_STAGES-1:0][NPINS-1:0]   sync_q;
   logic [NPINS-1:0]                    s;
   logic [NPINS-1:0]                    exp_q, exp_d;
   logic                                prev_zero_q, prev_zero_d;
   logic [NPINS-1:0]                    mask_d;
   logic [15:0]                         err_d, frame_d;
   logic [CW-1:0]                       clean_q, clean_d;
   logic [MW-1:0]                       miss_q, miss_d;
   logic                                pass_d;
   logic                                ferr_q, ferr_d;
   logic                                tog_q, tog_d;
   logic                                mismatch;

   assign s        = sync_q[SYNC_STAGES-1];
   assign locked   = (state_q == LOCKED);
   assign mismatch = locked && (s != exp_q);
   assign led      = pass | (locked & tog_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q      <= '0;
         state_q     <= HUNT;
         exp_q       <= '0;
         prev_zero_q <= 1'b0;
         fault_mask  <= '0;
         err_count   <= '0;
         frame_count <= '0;
         clean_q     <= '0;
         miss_q      <= '0;
         pass        <= 1'b0;
         ferr_q      <= 1'b0;
         tog_q       <= 1'b0;
      end else begin
         sync_q      <= {sync_q[SYNC_STAGES-2:0], pins_in};
         state_q     <= state_d;
         exp_q       <= exp_d;
         prev_zero_q <= prev_zero_d;
         fault_mask  <= mask_d;
         err_count   <= err_d;
         frame_count <= frame_d;
         clean_q     <= clean_d;
         miss_q      <= miss_d;
         pass        <= pass_d;
         ferr_q      <= ferr_d;
         tog_q       <= tog_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      exp_d       = exp_q;
      prev_zero_d = (s == '0);
      mask_d      = fault_mask;
      err_d       = err_count;
      frame_d     = frame_count;
      clean_d     = clean_q;
      miss_d      = miss_q;
      pass_d      = pass;
      ferr_d      = ferr_q;
      tog_d       = tog_q;

      // Clear first so a same-cycle mismatch lands on top of the cleared state.
      if (clr_faults) begin
         mask_d  = '0;
         err_d   = '0;
         clean_d = '0;
         pass_d  = 1'b0;
      end

      case (state_q)
         HUNT: begin
            miss_d = '0;
            ferr_d = 1'b0;
            tog_d  = 1'b0;
            if (prev_zero_q && s == TOP) begin
               state_d = LOCKED;
               exp_d   = TOP >> 1;
            end
         end
         LOCKED: begin
            exp_d = (exp_q == '0) ? TOP : (exp_q >> 1);
            if (mismatch) begin
               mask_d  = mask_d | (s ^ exp_q);
               if (err_d != 16'hFFFF) err_d = err_d + 16'd1;
               miss_d  = miss_q + MW'(1);
               clean_d = '0;
               pass_d  = 1'b0;
               ferr_d  = 1'b1;
            end else begin
               miss_d = '0;
            end
            if (exp_q == '0) begin
               frame_d = frame_count + 16'd1;
               if (!ferr_d && clean_d != CW'(PASS_FRAMES)) clean_d = clean_d + CW'(1);
               pass_d = (clean_d == CW'(PASS_FRAMES));
               ferr_d = 1'b0;
               tog_d  = ~tog_q;
            end
            if (miss_d == MW'(LOSS_THRESH)) begin
               state_d = HUNT;
               miss_d  = '0;
               pass_d  = 1'b0;
               ferr_d  = 1'b0;
               tog_d   = 1'b0;
            end
         end
         default: state_d = HUNT;
      endcase
   end

endmodule

// File: tb/tb_pin_test_checker.sv
// Scoreboard bench for pin_test_checker: a faulty-generator stimulus feeds the DUT and a
// phase-counter reference model; a monitor compares every registered output each cycle.
module tb_pin_test_checker;
   localparam int NPINS = 26, SS = 2, PF = 16, LT = 4;

   logic clk = 1'b0;
   logic rst = 1'b1, clr_faults = 1'b0;
   logic [NPINS-1:0] pins_in = '0;
   logic locked, pass, led;
   logic [NPINS-1:0] fault_mask;
   logic [15:0] err_count, frame_count;

   pin_test_checker #(.NPINS(NPINS), .SYNC_STAGES(SS), .PASS_FRAMES(PF), .LOSS_THRESH(LT)) dut (
      .clk(clk), .rst(rst), .clr_faults(clr_faults), .pins_in(pins_in),
      .locked(locked), .pass(pass), .fault_mask(fault_mask),
      .err_count(err_count), .frame_count(frame_count), .led(led));

   always #5 clk = ~clk;

   typedef struct packed {
      logic             locked;
      logic             pass;
      logic [NPINS-1:0] fm;
      logic [15:0]      ec;
      logic [15:0]      fc;
      logic             led;
   } exp_t;

   exp_t q[$];
   int vectors = 0, miscompares = 0;

   // reference model state
   logic [NPINS-1:0] msync[SS];
   bit mlocked, mprevz, mpass, mferr, mtog;
   int mphase, mmiss, mcrun, mec, mfc;
   logic [NPINS-1:0] mfm;

   // generator state
   int gphase = 0;
   logic [NPINS-1:0] stuck0 = '0;
   bit short34 = 0, halt = 0;
   int noise_pct = 0;

   function automatic logic [NPINS-1:0] pat(int k);
      logic [NPINS-1:0] v = '0;
      if (k < NPINS) v[NPINS-1-k] = 1'b1;
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < SS; i++) msync[i] = '0;
      mlocked = 0; mprevz = 0; mpass = 0; mferr = 0; mtog = 0;
      mphase = 0; mmiss = 0; mcrun = 0; mec = 0; mfc = 0; mfm = '0;
   endtask

   task automatic model_step(bit r, bit c, logic [NPINS-1:0] p);
      logic [NPINS-1:0] s, e;
      if (r) begin
         model_reset();
         return;
      end
      s = msync[SS-1];
      for (int i = SS-1; i > 0; i--) msync[i] = msync[i-1];
      msync[0] = p;
      if (c) begin mfm = '0; mec = 0; mcrun = 0; mpass = 0; end
      if (!mlocked) begin
         if (mprevz && s == pat(0)) begin
            mlocked = 1; mphase = 1; mmiss = 0; mferr = 0; mtog = 0;
         end
      end else begin
         e = pat(mphase);
         if (s != e) begin
            mfm |= s ^ e;
            if (mec < 65535) mec++;
            mmiss++; mcrun = 0; mpass = 0; mferr = 1;
         end else mmiss = 0;
         if (mphase == NPINS) begin
            mfc = (mfc + 1) % 65536;
            if (!mferr && mcrun < PF) mcrun++;
            mpass = (mcrun == PF);
            mferr = 0;
            mtog = !mtog;
         end
         mphase = (mphase + 1) % (NPINS + 1);
         if (mmiss == LT) begin
            mlocked = 0; mmiss = 0; mpass = 0; mferr = 0; mtog = 0;
         end
      end
      mprevz = (s == '0);
   endtask

   task automatic cycle(bit r, bit c);
      logic [NPINS-1:0] g;
      exp_t x;
      @(negedge clk);
      g = halt ? '0 : pat(gphase);
      g &= ~stuck0;
      if (short34) begin g[3] = g[3] | g[4]; g[4] = g[3]; end
      if (noise_pct > 0 && $urandom_range(99, 0) < noise_pct) g[$urandom_range(NPINS-1, 0)] ^= 1'b1;
      rst = r; clr_faults = c; pins_in = g;
      model_step(r, c, g);
      x.locked = mlocked; x.pass = mpass; x.fm = mfm; x.ec = mec[15:0]; x.fc = mfc[15:0];
      x.led = mpass | (mlocked & mtog);
      q.push_back(x);
      if (!halt) gphase = (gphase + 1) % (NPINS + 1);
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] want);
      if (act !== want) begin
         miscompares++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, want);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            vectors++;
            chk("locked", 32'(locked), 32'(e.locked));
            chk("pass", 32'(pass), 32'(e.pass));
            chk("fault_mask", 32'(fault_mask), 32'(e.fm));
            chk("err_count", 32'(err_count), 32'(e.ec));
            chk("frame_count", 32'(frame_count), 32'(e.fc));
            chk("led", 32'(led), 32'(e.led));
         end
      end
   end

   initial begin : stim
      int budget;
      model_reset();
      repeat (3) cycle(1, 0);
      gphase = $urandom_range(NPINS, 0);
      repeat (520) cycle(0, 0);            // clean loopback: lock, then pass
      stuck0 = '0; stuck0[7] = 1'b1;
      repeat (120) cycle(0, 0);            // pin 7 stuck-at-0
      stuck0 = '0;
      cycle(0, 1);                         // clear with fault removed
      repeat (480) cycle(0, 0);
      short34 = 1;
      repeat (100) cycle(0, 0);            // pins 3/4 wired-OR
      short34 = 0;
      halt = 1;
      repeat (60) cycle(0, 0);             // generator stalls at zero
      halt = 0;
      repeat (80) cycle(0, 0);
      stuck0[$urandom_range(NPINS-1, 0)] = 1'b1;
      repeat (50) cycle(0, 0);
      cycle(1, 0);                         // mid-frame reset
      stuck0 = '0;
      repeat (60) cycle(0, 0);
      noise_pct = 3;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(199, 0) == 0) gphase = $urandom_range(NPINS, 0);
         cycle($urandom_range(99, 0) == 0, $urandom_range(49, 0) == 0);
      end
      noise_pct = 0;
      cycle(0, 1);
      repeat (100) cycle(0, 0);
      budget = 10;
      while (q.size() > 0 && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      #2;
      if (q.size() > 0) begin
         miscompares++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
